ahbpassthru_target: RTL and testbench
=====================================

// Module: ahbpassthru_target
// PURPOSE
//  Off-chip end of the AHB slave pass-through: receives the passed-through slave bus and answers
//  as a real AHB slave. Backing store is a word-organised SRAM with a programmable wait-state count.
//  Returns two-cycle ERROR for bad accesses and raises a doorbell interrupt. Used on the companion
//  FPGA/test board and as the bench responder for pass-through integration.
// PARAMETERS
//  DATAWIDTH   32            data bus width; only 32 supported
//  ADDRBITS    10            log2 of SRAM depth in words (1024 words = 4 KiB window)
//  BASEADDR    32'h8000_0000 window base; compared on haddr[31:ADDRBITS+2]
//  WAITSTATES  0             extra hready_o-low cycles per OKAY data phase (0..15)
//  NUMIRQ      32            width of hirq_o
//  HIRQNUM     3             hirq_o bit pulsed by a doorbell write
//  CACHEABLE   1'b0          value driven on hcache_o
// PORTS
//  clk        in   1         clock, all logic on rising edge
//  rst        in   1         synchronous reset, active high
//  hsel       in   1         slave select
//  haddr      in   32        byte address
//  hwrite     in   1         1 = write
//  htrans     in   2         IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  hsize      in   3         000 byte, 001 half, 010 word
//  hburst     in   3         burst type; ignored, every beat is decoded independently
//  hwdata     in   32        write data, sampled in the data phase
//  hprot      in   4         ignored
//  hready     in   1         bus-wide transfer done
//  hmaster    in   4         ignored
//  hmastlock  in   1         ignored
//  hready_o   out  1         this slave's transfer done
//  hresp      out  2         00 OKAY, 01 ERROR
//  hrdata     out  32        read data, valid when hready_o=1 in a read data phase
//  hsplit     out  16        tied 0
//  hcache_o   out  1         = CACHEABLE
//  hirq_o     out  NUMIRQ    doorbell interrupt
// BEHAVIOUR
//  Reset: hready_o=1, hresp=00, hrdata=0, hirq_o=0, state IDLE, pending write dropped.
//  SRAM contents are not reset. Reset mid-transfer aborts it without modifying SRAM.
//  Accept address phase when hsel & hready & htrans[1]. IDLE/BUSY, or hsel=0, gives an OKAY
//  zero-wait response and no state change.
//  Error checks at accept: hsize>2; misaligned (half & a[0], word & a[1:0]!=0);
//  haddr[31:ADDRBITS+2] != BASEADDR[31:ADDRBITS+2].
//  States:
//   IDLE  --accept ok, WAITSTATES=0-------> DATA
//   IDLE  --accept ok, WAITSTATES>0-------> WAIT
//   IDLE  --accept bad--------------------> ERR1
//   WAIT  hready_o=0, hresp=00; counter 1..WAITSTATES; -> DATA on last count
//   DATA  hready_o=1, hresp=00; completes the beat; may accept next address phase
//         -> WAIT/DATA/ERR1 if accepted, else IDLE
//   ERR1  hready_o=0, hresp=01 -> ERR2
//   ERR2  hready_o=1, hresp=01; may accept next address phase, same rules as DATA
//  Pipelining: back-to-back beats at full rate when WAITSTATES=0, i.e. one beat per cycle.
//  Address fields and byte-lane mask are registered at accept. No address is accepted
//  while hready_o=0.
//  Lanes are big-endian: byte offset 0 = bits[31:24], 3 = bits[7:0]. Half at offset 0 = [31:16].
//  Write: byte enables from hsize/haddr[1:0]. SRAM is written at the clock edge ending the
//  DATA cycle using hwdata. A failed (ERROR) beat never writes.
//  Read: word fetched at accept (or at the last WAIT cycle) and held in hrdata through DATA.
//  hrdata returns the full word regardless of hsize. hrdata is unchanged outside read DATA.
//  Hazard: a read accepted in the DATA cycle of a write to the same word returns the merged
//  new bytes (forwarding), never stale data.
//  Doorbell: a completed OKAY write to word index 2**ADDRBITS-1 sets hirq_o[HIRQNUM]=1 for
//  exactly the next cycle. All other hirq_o bits stay 0.
// TESTING
//  Reset: hold rst 2 cycles -> hready_o=1, hresp=00, hrdata=0, hirq_o=0.
//  WAITSTATES=0, write word 0x1234_5678 @0x8000_0010, then read @0x8000_0010 ->
//   hrdata=0x1234_5678, hready_o=1 every cycle.
//  Byte write 0xAB @0x8000_0011 (hsize=0), then word read @0x8000_0010 -> 0x12AB_5678.
//  WAITSTATES=2, read ->
//   hready_o 0,0,1 with data on the third cycle.
//  Read @0x9000_0000 (outside window) ->
//   cycle1 hready_o=0/hresp=01, cycle2 hready_o=1/hresp=01.
//   A following valid read then completes OKAY.
//  Write 0xCAFE_F00D @0x8000_0020 immediately followed by a read of the same address ->
//   0xCAFE_F00D (forwarded).
//  Write to @0x8000_0FFC -> hirq_o[3] high one cycle.
//  Half write @0x8000_0001 -> ERROR pair, SRAM unchanged.

Source files
------------

// File: rtl/ahbpassthru_target.sv
// Off-chip AHB slave responder: word SRAM behind a fixed window, programmable wait states,
// two-cycle ERROR on bad beats and a doorbell interrupt on writes to the top word.
module ahbpassthru_target #(
    parameter int          DATAWIDTH  = 32,
    parameter int          ADDRBITS   = 10,
    parameter logic [31:0] BASEADDR   = 32'h8000_0000,
    parameter int          WAITSTATES = 0,
    parameter int          NUMIRQ     = 32,
    parameter int          HIRQNUM    = 3,
    parameter logic        CACHEABLE  = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic                  hwrite,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [DATAWIDTH-1:0]  hwdata,
    input  logic [3:0]            hprot,
    input  logic                  hready,
    input  logic [3:0]            hmaster,
    input  logic                  hmastlock,
    output logic                  hready_o,
    output logic [1:0]            hresp,
    output logic [DATAWIDTH-1:0]  hrdata,
    output logic [15:0]           hsplit,
    output logic                  hcache_o,
    output logic [NUMIRQ-1:0]     hirq_o
);
    localparam int TOPB = ADDRBITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    logic [DATAWIDTH-1:0] mem [2**ADDRBITS];

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [ADDRBITS-1:0]   idx_q, idx_d;
    logic [3:0]            be_q, be_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]  rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic                  own_ready, accept, bad, wr_now;
    logic [ADDRBITS-1:0]   a_idx;
    logic [3:0]            a_be;
    logic [DATAWIDTH-1:0]  wr_word, fwd_word;

    wire unused_ok = ^{hburst, hprot, hmaster, hmastlock};

    // Byte-lane merge; be bit i selects bits [8i+7:8i] (bit 3 = byte offset 0, big-endian).
    function automatic logic [DATAWIDTH-1:0] merge(input logic [DATAWIDTH-1:0] old_w,
                                                   input logic [DATAWIDTH-1:0] new_w,
                                                   input logic [3:0] be);
        logic [DATAWIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always_comb begin
        own_ready = (state_q == S_IDLE) || (state_q == S_DATA) || (state_q == S_ERR2);
        accept    = hsel && hready && htrans[1] && own_ready;
        bad       = (hsize > 3'd2)
                 || ((hsize == 3'd1) && haddr[0])
                 || ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
                 || (haddr[31:TOPB] != BASEADDR[31:TOPB]);
        a_idx     = haddr[TOPB-1:2];
        case (hsize)
            3'd0:    a_be = 4'b1000 >> haddr[1:0];
            3'd1:    a_be = haddr[1] ? 4'b0011 : 4'b1100;
            default: a_be = 4'b1111;
        endcase
        wr_now   = (state_q == S_DATA) && write_q;
        wr_word  = merge(mem[idx_q], hwdata, be_q);
        // A read accepted during a write's data phase sees the bytes being written this edge.
        fwd_word = (wr_now && (idx_q == a_idx)) ? wr_word : mem[a_idx];
    end

    always_comb begin
        state_d = state_q;
        write_d = write_q;
        idx_d   = idx_q;
        be_d    = be_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        irq_d   = wr_now && (&idx_q);
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'(WAITSTATES)) begin
                    state_d = S_DATA;
                    if (!write_q) rdata_d = mem[idx_q];
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            default: begin
                if (accept) begin
                    if (bad) begin
                        state_d = S_ERR1;
                        write_d = 1'b0;
                    end else begin
                        write_d = hwrite;
                        idx_d   = a_idx;
                        be_d    = a_be;
                        if (WAITSTATES == 0) begin
                            state_d = S_DATA;
                            if (!hwrite) rdata_d = fwd_word;
                        end else begin
                            state_d = S_WAIT;
                            cnt_d   = 4'd1;
                        end
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            idx_q   <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            idx_q   <= idx_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_now) mem[idx_q] <= wr_word;
    end

    assign hready_o = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign hresp    = ((state_q == S_ERR1) || (state_q == S_ERR2)) ? 2'b01 : 2'b00;
    assign hrdata   = rdata_q;
    assign hsplit   = 16'h0000;
    assign hcache_o = CACHEABLE;
    assign hirq_o   = irq_q ? (NUMIRQ'(1) << HIRQNUM) : '0;
endmodule

// File: tb/tb_ahbpassthru_target.sv
// Directed bench: one zero-wait responder and one two-wait-state responder on a shared bus.
module tb_ahbpassthru_target;
    logic        clk = 1'b0;
    logic        rst;
    logic        hsel0, hsel2, hwrite, hmastlock, use2;
    logic [31:0] haddr, hwdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot, hmaster;
    wire         hready_bus;
    logic        hready_o0, hready_o2, hcache0, hcache2;
    logic [1:0]  hresp0, hresp2;
    logic [31:0] hrdata0, hrdata2, hirq0, hirq2;
    logic [15:0] hsplit0, hsplit2;
    int tests = 0, fails = 0;

    always #5 clk = ~clk;
    assign hready_bus = use2 ? hready_o2 : hready_o0;

    ahbpassthru_target #(.WAITSTATES(0)) dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hprot(hprot), .hready(hready_bus),
        .hmaster(hmaster), .hmastlock(hmastlock), .hready_o(hready_o0), .hresp(hresp0),
        .hrdata(hrdata0), .hsplit(hsplit0), .hcache_o(hcache0), .hirq_o(hirq0));

    ahbpassthru_target #(.WAITSTATES(2)) dut2 (
        .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite), .htrans(htrans),
        .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hprot(hprot), .hready(hready_bus),
        .hmaster(hmaster), .hmastlock(hmastlock), .hready_o(hready_o2), .hresp(hresp2),
        .hrdata(hrdata2), .hsplit(hsplit2), .hcache_o(hcache2), .hirq_o(hirq2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic addr(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic idle();
        htrans = 2'b00; hwrite = 1'b0;
    endtask

    initial begin
        rst = 1'b1; hsel0 = 1'b1; hsel2 = 1'b0; use2 = 1'b0; hwrite = 1'b0; hmastlock = 1'b0;
        haddr = 32'h0; hwdata = 32'h0; htrans = 2'b00; hsize = 3'd2; hburst = 3'd0;
        hprot = 4'h0; hmaster = 4'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_hready", {31'b0, hready_o0}, 32'd1);
        chk("rst_hresp", {30'b0, hresp0}, 32'd0);
        chk("rst_hrdata", hrdata0, 32'd0);
        chk("rst_hirq", hirq0, 32'd0);
        chk("rst_hrdata2", hrdata2, 32'd0);
        chk("hsplit_hcache", {hsplit0, 15'b0, hcache0}, 32'd0);

        // Word write then back-to-back read of the same word
        addr(1'b1, 32'h8000_0010, 3'd2); tick();
        chk("wr_data_ready", {31'b0, hready_o0}, 32'd1);
        hwdata = 32'h1234_5678; addr(1'b0, 32'h8000_0010, 3'd2); tick();
        chk("rd_ready", {31'b0, hready_o0}, 32'd1);
        chk("rd_word", hrdata0, 32'h1234_5678);
        idle(); tick();

        // Byte write at offset 1 lands in bits [23:16] only
        addr(1'b1, 32'h8000_0011, 3'd0); tick();
        hwdata = 32'hFFAB_FFFF; idle(); tick();
        addr(1'b0, 32'h8000_0010, 3'd2); tick();
        idle();
        chk("byte_merge", hrdata0, 32'h12AB_5678);
        tick();

        // Outside the window: two-cycle error, then a valid read accepted in ERR2
        addr(1'b0, 32'h9000_0000, 3'd2); tick();
        idle();
        chk("err1", {30'b0, hresp0, 1'b0, hready_o0}, {30'b0, 2'b01, 1'b0, 1'b0});
        tick();
        addr(1'b0, 32'h8000_0010, 3'd2);
        chk("err2", {30'b0, hresp0, 1'b0, hready_o0}, {30'b0, 2'b01, 1'b0, 1'b1});
        tick();
        idle();
        chk("after_err_resp", {30'b0, hresp0, 1'b0, hready_o0}, {30'b0, 2'b00, 1'b0, 1'b1});
        chk("after_err_data", hrdata0, 32'h12AB_5678);
        tick();

        // Write immediately followed by read of the same word is forwarded
        addr(1'b1, 32'h8000_0020, 3'd2); tick();
        hwdata = 32'hCAFE_F00D; addr(1'b0, 32'h8000_0020, 3'd2); tick();
        idle();
        chk("fwd", hrdata0, 32'hCAFE_F00D);
        tick();

        // Doorbell on the top word
        addr(1'b1, 32'h8000_0FFC, 3'd2); tick();
        hwdata = 32'h0000_0001; idle();
        chk("irq_before", hirq0, 32'd0);
        tick();
        chk("irq_pulse", hirq0, 32'h0000_0008);
        tick();
        chk("irq_clear", hirq0, 32'd0);

        // Misaligned half write errors and leaves word 0 untouched
        addr(1'b1, 32'h8000_0000, 3'd2); tick();
        hwdata = 32'h5555_AAAA; idle(); tick();
        addr(1'b1, 32'h8000_0001, 3'd1); tick();
        hwdata = 32'hFFFF_FFFF; idle();
        chk("half_err1", {30'b0, hresp0, 1'b0, hready_o0}, {30'b0, 2'b01, 1'b0, 1'b0});
        tick();
        chk("half_err2", {30'b0, hresp0, 1'b0, hready_o0}, {30'b0, 2'b01, 1'b0, 1'b1});
        tick();
        addr(1'b0, 32'h8000_0000, 3'd2); tick();
        idle();
        chk("half_no_write", hrdata0, 32'h5555_AAAA);
        tick();

        // Two wait states: write then read on the second responder
        hsel0 = 1'b0; hsel2 = 1'b1; use2 = 1'b1;
        addr(1'b1, 32'h8000_0010, 3'd2); tick();
        hwdata = 32'hDEAD_BEEF; idle();
        chk("ws_wr_w1", {31'b0, hready_o2}, 32'd0);
        tick();
        chk("ws_wr_w2", {31'b0, hready_o2}, 32'd0);
        tick();
        chk("ws_wr_data", {31'b0, hready_o2}, 32'd1);
        tick();
        addr(1'b0, 32'h8000_0010, 3'd2); tick();
        idle();
        chk("ws_rd_w1", {31'b0, hready_o2}, 32'd0);
        chk("ws_rd_hold", hrdata2, 32'd0);
        tick();
        chk("ws_rd_w2", {31'b0, hready_o2}, 32'd0);
        tick();
        chk("ws_rd_ready", {31'b0, hready_o2}, 32'd1);
        chk("ws_rd_data", hrdata2, 32'hDEAD_BEEF);
        chk("ws_rd_resp", {30'b0, hresp2}, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
